// File: rtl/symbol_stream_feeder.sv
// symbol_stream_feeder
//   Symbol source for the Aho-Corasick matcher. A local buffer of SYM_W-bit
//   symbols is loaded while idle. On i_start the first i_len symbols are
//   streamed out using the matcher's two-phase handshake: one INITIALIZE
//   cycle, then one EN cycle carrying the symbol. This repeats for every
//   symbol, and the stream ends with a trailing INITIALIZE cycle.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous reset, active-low
//   i_wr_en        buffer write strobe (honoured only while idle)
//   i_wr_addr      buffer write address
//   i_wr_data      buffer write data
//   i_len          number of symbols to stream, sampled with i_start
//   i_start        begin streaming (idle only)
//   i_stall        pause streaming while high
//   i_abort        cancel streaming
//   o_en           matcher symbol-valid
//   o_initialize   matcher initialize phase
//   o_string       symbol to matcher, valid when o_en=1
//   o_sym_idx      index of the symbol currently or next presented
//   o_busy         streaming in progress
//   o_done         one-cycle pulse on normal completion
module symbol_stream_feeder #(
    parameter int SYM_W  = 4,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [SYM_W-1:0]  i_wr_data,
    input  logic [ADDR_W:0]   i_len,
    input  logic              i_start,
    input  logic              i_stall,
    input  logic              i_abort,
    output logic              o_en,
    output logic              o_initialize,
    output logic [SYM_W-1:0]  o_string,
    output logic [ADDR_W-1:0] o_sym_idx,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FEED,
        S_TAIL,
        S_FIN
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W-1:0]   r_sym_idx;
    logic [SYM_W-1:0]    r_string;
    logic                r_en;
    logic                r_init;
    logic                r_busy;
    logic                r_done;
    logic [SYM_W-1:0]    r_buf [DEPTH];

    state_t              w_state_nxt;
    logic [ADDR_W:0]     w_len_nxt;
    logic [ADDR_W-1:0]   w_idx_nxt;
    logic [SYM_W-1:0]    w_string_nxt;
    logic                w_en_nxt;
    logic                w_init_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [ADDR_W:0]     w_len_clamped;
    logic                w_last;

    assign w_len_clamped = (i_len > MAX_LEN) ? MAX_LEN : i_len;
    // The symbol in FEED is the last one when idx+1 reaches the latched length.
    assign w_last = (({1'b0, r_sym_idx} + (ADDR_W+1)'(1)) == r_len);

    // Buffer contents survive reset; writes only land while idle, so a write
    // issued together with i_start is already in place for the first read.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && (r_state == S_IDLE)) begin
            r_buf[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_sym_idx <= '0;
            r_string  <= '0;
            r_en      <= 1'b0;
            r_init    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_len     <= w_len_nxt;
            r_sym_idx <= w_idx_nxt;
            r_string  <= w_string_nxt;
            r_en      <= w_en_nxt;
            r_init    <= w_init_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Outputs are registered: this block decides what the next cycle shows.
    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_idx_nxt    = r_sym_idx;
        w_string_nxt = r_string;
        w_en_nxt     = 1'b0;
        w_init_nxt   = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_len_nxt = w_len_clamped;
                    w_idx_nxt = '0;
                    if (w_len_clamped == '0) begin
                        w_state_nxt = S_FIN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_INIT;
                        w_init_nxt  = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end
                end
            end

            S_INIT, S_FEED, S_TAIL: begin
                if (i_abort) begin
                    w_state_nxt  = S_IDLE;
                    w_idx_nxt    = '0;
                    w_string_nxt = '0;
                end else if (i_stall) begin
                    // Freeze state and index and blank both strobes; the
                    // sequence resumes where it left off once stall drops.
                    w_busy_nxt = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                    case (r_state)
                        S_INIT: begin
                            w_state_nxt  = S_FEED;
                            w_en_nxt     = 1'b1;
                            w_string_nxt = r_buf[r_sym_idx];
                        end
                        S_FEED: begin
                            w_init_nxt = 1'b1;
                            if (w_last) begin
                                w_state_nxt = S_TAIL;
                            end else begin
                                w_state_nxt = S_INIT;
                                w_idx_nxt   = r_sym_idx + ADDR_W'(1);
                            end
                        end
                        default: begin
                            w_state_nxt = S_FIN;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_idx_nxt   = '0;
                        end
                    endcase
                end
            end

            S_FIN: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_en         = r_en;
    assign o_initialize = r_init;
    assign o_string     = r_string;
    assign o_sym_idx    = r_sym_idx;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_symbol_stream_feeder.sv
module tb_symbol_stream_feeder;

    localparam int SYM_W  = 4;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [SYM_W-1:0]  wr_data = '0;
    logic [ADDR_W:0]   len_in = '0;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic              abort = 1'b0;
    logic              o_en;
    logic              o_initialize;
    logic [SYM_W-1:0]  o_string;
    logic [ADDR_W-1:0] o_sym_idx;
    logic              o_busy;
    logic              o_done;

    int checks = 0;
    int errors = 0;

    logic [SYM_W-1:0] mbuf [DEPTH];
    int sym_q[$];
    int idx_q[$];
    int phase_q[$];   // 1=INIT 2=FEED 3=TAIL 4=DONE

    symbol_stream_feeder #(.SYM_W(SYM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .i_wr_en(wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .i_len(len_in),
        .i_start(start),
        .i_stall(stall),
        .i_abort(abort),
        .o_en(o_en),
        .o_initialize(o_initialize),
        .o_string(o_string),
        .o_sym_idx(o_sym_idx),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic write_buf(input int a, input int d);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_addr = a[ADDR_W-1:0];
        wr_data = d[SYM_W-1:0];
        mbuf[a] = d[SYM_W-1:0];
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Streams len symbols starting at cycle 0 and checks every following cycle
    // against a phase/symbol scoreboard. stall is high in cycles st_lo..st_hi,
    // abort in cycle ab_c, a second start in cycle st2_c; sw requests a
    // buffer write in the same cycle as start.
    task automatic run_stream(input string name, input int len,
                              input int st_lo, input int st_hi, input int ab_c,
                              input int st2_c, input bit sw, input int sw_a,
                              input int sw_d, input int exp_done, input int ncyc);
        int n, ph, done_c, exp_sym, exp_idx;
        bit m_busy, m_abort, p_stall, p_abort, have_str;
        bit chk_feed, chk_hold, chk_zero;
        logic [3:0] exp_v, act_v;
        logic [SYM_W-1:0] last_str;

        n = (len > DEPTH) ? DEPTH : len;
        if (sw) mbuf[sw_a] = sw_d[SYM_W-1:0];
        sym_q.delete(); idx_q.delete(); phase_q.delete();
        for (int i = 0; i < n; i++) begin
            phase_q.push_back(1);
            phase_q.push_back(2);
            sym_q.push_back(int'(mbuf[i]));
            idx_q.push_back(i);
        end
        if (n > 0) phase_q.push_back(3);
        phase_q.push_back(4);

        @(posedge clk); #1;
        start   = 1'b1;
        len_in  = len[ADDR_W:0];
        stall   = (st_lo <= 0) && (st_hi >= 0);
        abort   = (ab_c == 0);
        wr_en   = sw;
        wr_addr = sw_a[ADDR_W-1:0];
        wr_data = sw_d[SYM_W-1:0];
        p_stall = stall;
        p_abort = abort;
        m_busy = 0; m_abort = 0; have_str = 0; last_str = '0;
        done_c = -1; exp_sym = 0; exp_idx = 0;

        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start = (c == st2_c);
            stall = (c >= st_lo) && (c <= st_hi);
            abort = (c == ab_c);
            wr_en = 1'b0;
            exp_v = 4'b0000;
            chk_feed = 0; chk_hold = 0; chk_zero = 0;
            if (m_abort) begin
                exp_v = 4'b0000;
            end else if (m_busy && p_abort) begin
                m_abort = 1; m_busy = 0; chk_zero = 1;
                phase_q.delete(); sym_q.delete(); idx_q.delete();
                last_str = '0;
            end else if (m_busy && p_stall) begin
                exp_v = 4'b0010;
                chk_hold = have_str;
            end else if (phase_q.size() > 0) begin
                ph = phase_q.pop_front();
                case (ph)
                    1: begin exp_v = 4'b0110; m_busy = 1; end
                    2: begin
                        exp_v = 4'b1010; m_busy = 1; chk_feed = 1;
                        exp_sym = sym_q.pop_front();
                        exp_idx = idx_q.pop_front();
                        last_str = exp_sym[SYM_W-1:0];
                        have_str = 1;
                    end
                    3: begin exp_v = 4'b0110; m_busy = 1; end
                    default: begin exp_v = 4'b0001; m_busy = 0; end
                endcase
            end
            p_stall = stall;
            p_abort = abort;

            @(negedge clk);
            act_v = {o_en, o_initialize, o_busy, o_done};
            if (o_done === 1'b1 && done_c < 0) done_c = c;
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d {en,init,busy,done} got %b want %b", name, c, act_v, exp_v);
            end
            if (chk_feed) begin
                checks++;
                if (o_string !== exp_sym[SYM_W-1:0] || o_sym_idx !== exp_idx[ADDR_W-1:0]) begin
                    errors++;
                    $display("FAIL %s cycle %0d string/idx got %0d/%0d want %0d/%0d",
                             name, c, o_string, o_sym_idx, exp_sym, exp_idx);
                end
            end
            if (chk_hold) begin
                checks++;
                if (o_string !== last_str) begin
                    errors++;
                    $display("FAIL %s cycle %0d stall hold string got %0d want %0d", name, c, o_string, last_str);
                end
            end
            if (chk_zero) begin
                checks++;
                if (o_string !== '0 || o_sym_idx !== '0) begin
                    errors++;
                    $display("FAIL %s cycle %0d abort string/idx got %0d/%0d want 0/0", name, c, o_string, o_sym_idx);
                end
            end
        end
        stall = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (done_c != exp_done) begin
            errors++;
            $display("FAIL %s done cycle got %0d want %0d", name, done_c, exp_done);
        end
        if (!m_abort) begin
            checks++;
            if (sym_q.size() != 0) begin
                errors++;
                $display("FAIL %s symbols left unstreamed got %0d want 0", name, sym_q.size());
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_en, o_initialize, o_busy, o_done} !== 4'b0000 || o_string !== '0 || o_sym_idx !== '0) begin
            errors++;
            $display("FAIL reset outputs got %b/%0d/%0d want 0000/0/0",
                     {o_en, o_initialize, o_busy, o_done}, o_string, o_sym_idx);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 8; i++) write_buf(i, i + 1);
    endtask

    task automatic test_stream();
        run_stream("stream", 8, -1, -1, -1, -1, 0, 0, 0, 18, 22);
    endtask

    task automatic test_empty();
        // stall and abort in IDLE must not matter
        run_stream("empty", 0, 0, 0, 0, -1, 0, 0, 0, 1, 4);
    endtask

    task automatic test_stall();
        run_stream("stall", 8, 7, 9, -1, -1, 0, 0, 0, 21, 25);
    endtask

    task automatic test_abort();
        run_stream("abort", 8, 7, 7, 7, -1, 0, 0, 0, -1, 14);
        run_stream("replay", 8, -1, -1, -1, -1, 0, 0, 0, 18, 22);
    endtask

    task automatic test_start_ignored();
        run_stream("busy_start", 8, -1, -1, -1, 5, 0, 0, 0, 18, 22);
    endtask

    task automatic test_write_with_start();
        run_stream("wr_start", 2, -1, -1, -1, -1, 1, 0, 9, 6, 8);
    endtask

    task automatic test_reset_write_block();
        @(posedge clk); #1;
        start  = 1'b1;
        len_in = 6'd8;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            wr_en   = (c == 3);
            wr_addr = 5'd2;
            wr_data = 4'hF;
            rst_n   = (c != 8);
            @(negedge clk);
            if (c == 8) begin
                checks++;
                if (o_en !== 1'b1 || o_string !== mbuf[3]) begin
                    errors++;
                    $display("FAIL rst_pre cycle 8 en/string got %b/%0d want 1/%0d", o_en, o_string, mbuf[3]);
                end
            end
            if (c == 9) begin
                checks++;
                if ({o_en, o_initialize, o_busy, o_done} !== 4'b0000 || o_string !== '0 || o_sym_idx !== '0) begin
                    errors++;
                    $display("FAIL rst_mid outputs got %b/%0d/%0d want 0000/0/0",
                             {o_en, o_initialize, o_busy, o_done}, o_string, o_sym_idx);
                end
            end
            if (c > 9) begin
                checks++;
                if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_after cycle %0d done/busy got %b/%b want 0/0", c, o_done, o_busy);
                end
            end
        end
        wr_en = 1'b0;
        run_stream("rst_restart", 8, -1, -1, -1, -1, 0, 0, 0, 18, 22);
    endtask

    task automatic test_clamp();
        for (int i = 0; i < DEPTH; i++) write_buf(i, i % 16);
        run_stream("clamp", 40, -1, -1, -1, -1, 0, 0, 0, 66, 70);
    endtask

    initial begin
        test_reset();
        load_ramp();
        test_stream();
        test_empty();
        test_stall();
        test_abort();
        test_start_ignored();
        test_reset_write_block();
        test_write_with_start();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
